// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline stage register: valid/ready handshake with stall, flush and an
// optional skid entry so that upstream ready comes straight from a flop.
module pipe_stage_elastic #(
    parameter int unsigned CTRL_W     = 16,
    parameter int unsigned DATA_W     = 160,
    parameter bit          SKID_EN    = 1'b1,
    parameter bit          FLUSH_DATA = 1'b1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        count
);

    logic              m_valid_q, m_valid_d;
    logic [CTRL_W-1:0] m_ctrl_q,  m_ctrl_d;
    logic [DATA_W-1:0] m_data_q,  m_data_d;
    logic              s_valid_q, s_valid_d;
    logic [CTRL_W-1:0] s_ctrl_q,  s_ctrl_d;
    logic [DATA_W-1:0] s_data_q,  s_data_d;
    logic              in_ready_q;
    logic [1:0]        count_q;
    logic              in_fire_c;
    logic              out_fire_c;

    // Without the skid entry, ready must see a same-cycle drain of the main entry.
    assign in_ready   = SKID_EN ? in_ready_q : (~m_valid_q | out_ready);
    assign in_fire_c  = in_valid & in_ready;
    assign out_fire_c = m_valid_q & out_ready;

    assign out_valid = m_valid_q;
    assign out_ctrl  = m_ctrl_q;
    assign out_data  = m_data_q;
    assign count     = count_q;

    // Next-state for main and skid entries.
    always_comb begin
        m_valid_d = m_valid_q;
        m_ctrl_d  = m_ctrl_q;
        m_data_d  = m_data_q;
        s_valid_d = s_valid_q;
        s_ctrl_d  = s_ctrl_q;
        s_data_d  = s_data_q;

        if (flush) begin
            m_valid_d = 1'b0;
            s_valid_d = 1'b0;
            m_ctrl_d  = '0;
            s_ctrl_d  = '0;
            if (FLUSH_DATA) begin
                m_data_d = '0;
                s_data_d = '0;
            end
        end else if (out_fire_c || !m_valid_q) begin
            if (SKID_EN && s_valid_q) begin
                m_valid_d = 1'b1;
                m_ctrl_d  = s_ctrl_q;
                m_data_d  = s_data_q;
                s_valid_d = 1'b0;
            end else if (in_fire_c) begin
                m_valid_d = 1'b1;
                m_ctrl_d  = in_ctrl;
                m_data_d  = in_data;
            end else begin
                // Bubble: control is cleared so a dead slot never carries live controls.
                m_valid_d = 1'b0;
                m_ctrl_d  = '0;
            end
        end else if (SKID_EN && in_fire_c) begin
            s_valid_d = 1'b1;
            s_ctrl_d  = in_ctrl;
            s_data_d  = in_data;
        end
    end

    // State registers; ready and count are registered from next-state.
    always_ff @(posedge CLK) begin
        if (RST) begin
            m_valid_q  <= 1'b0;
            m_ctrl_q   <= '0;
            m_data_q   <= '0;
            s_valid_q  <= 1'b0;
            s_ctrl_q   <= '0;
            s_data_q   <= '0;
            in_ready_q <= 1'b1;
            count_q    <= 2'd0;
        end else begin
            m_valid_q  <= m_valid_d;
            m_ctrl_q   <= m_ctrl_d;
            m_data_q   <= m_data_d;
            s_valid_q  <= s_valid_d;
            s_ctrl_q   <= s_ctrl_d;
            s_data_q   <= s_data_d;
            in_ready_q <= ~s_valid_d;
            count_q    <= 2'(m_valid_d) + 2'(s_valid_d);
        end
    end

endmodule

// File: doc/pipe_stage_elastic.md
Name: pipe_stage_elastic

Overview:
- Generic elastic pipeline stage register, the parametrised successor to the fixed per-stage pipeline registers (fetch/decode, decode/execute, ...).
- Carries a payload split into a control field (zeroed on flush/bubble) and a data field.
- Adds valid/ready handshaking and stall support, plus an optional skid entry so that upstream ready is driven from a flop.
- Every OTTER pipeline boundary instantiates it with its own widths.

Parameters:
- CTRL_W, 16: width of control payload (regWrite, memWrite, alu_fun, ...); zeroed on flush.
- DATA_W, 160: width of data payload (PC, instr, rs1, rs2, immed, ...).
- SKID_EN, 1: 1 = two-entry stage with registered in_ready; 0 = single entry with combinational in_ready.
- FLUSH_DATA, 1: 1 = flush also zeroes data fields; 0 = data fields hold their value on flush.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  synchronous, active-high reset.
- flush  in  1  kill all held entries (branch/jump mispredict).
- in_valid  in  1  upstream presents a payload.
- in_ready  out  1  stage can accept a payload this cycle.
- in_ctrl  in  CTRL_W  upstream control payload.
- in_data  in  DATA_W  upstream data payload.
- out_valid  out  1  stage presents a payload downstream.
- out_ready  in  1  downstream accepts this cycle (0 = stall).
- out_ctrl  out  CTRL_W  registered control payload.
- out_data  out  DATA_W  registered data payload.
- count  out  2  number of valid entries held (0..2).

Behaviour:
- Handshake events:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
  - in_valid must not depend on in_ready; out_valid must not depend on out_ready.
- State: main entry M {valid, ctrl, data}; skid entry S {valid, ctrl, data}, present only if SKID_EN=1.
- Outputs:
  - out_valid = M.valid; out_ctrl = M.ctrl; out_data = M.data, all driven directly from flops.
  - count = M.valid + S.valid.
- in_ready:
  - SKID_EN=1: in_ready = ~S.valid, driven from a flop with no combinational path from out_ready.
  - SKID_EN=0: in_ready = ~M.valid | out_ready.
- Priority per cycle: RST > flush > normal update.
- RST: M and S are cleared (valid, ctrl, data = 0). Out of reset: out_valid=0, out_ctrl=0, out_data=0, in_ready=1, count=0. Reset asserted mid-operation discards everything held, including a concurrent in_fire.
- flush (RST=0):
  - M.valid, S.valid <= 0; M.ctrl, S.ctrl <= 0.
  - Data fields <= 0 if FLUSH_DATA=1, else they hold.
  - A payload presented with in_fire in the flush cycle is discarded; upstream treats it as consumed.
  - A concurrent out_fire still counts as delivered.
- Normal update, SKID_EN=1:
  - If out_fire or ~M.valid:
    - If S.valid: M <= S, S.valid <= 0.
    - Else if in_fire: M <= input.
    - Else: M.valid <= 0 and M.ctrl <= 0 (bubble; data holds).
  - Else (M held by stall): if in_fire, S <= input.
- Normal update, SKID_EN=0:
  - If out_fire or ~M.valid: M <= input on in_fire, else bubble as above.
  - Else M holds.
- Timing:
  - Latency: 1 cycle from in_fire to out_valid when the stage is empty or streaming.
  - Throughput: 1 payload per cycle under continuous out_ready.
- Ordering is strictly FIFO: no drop, duplication or reordering except on flush or RST.
- Stall hold: while out_valid=1 and out_ready=0, out_ctrl and out_data are stable.
- Full (count=2): in_ready=0 in the same cycle count becomes 2. It returns to 1 the cycle after S drains into M.
- Simultaneous out_fire and in_fire with S empty: M is replaced by the input in the same edge, count stays 1.
- A bubble never shows a nonzero out_ctrl.

Test Plan:
1. RST=1 for 2 cycles with in_valid=1, in_ctrl=0xFFFF, in_data all-ones -> out_valid=0, out_ctrl=0, out_data=0, in_ready=1, count=0. The first in_fire after release appears on the output exactly 1 cycle later.
2. Streaming: out_ready=1, push ctrl 0x0001/0x0002/0x0003 on back-to-back cycles -> the outputs appear in order, one per cycle, 1-cycle latency, count=1 throughout. After the last push, out_valid=0 and out_ctrl=0.
3. Skid stall (SKID_EN=1): out_ready=0, push A (ctrl 0x00A1) then B (ctrl 0x00B2) -> count=2, in_ready=0, out_ctrl holds 0x00A1. C is held upstream. Raising out_ready -> A, B, C delivered on consecutive cycles; in_ready returns to 1 one cycle after B moves to M.
4. Flush at count=2 with in_valid=1 -> next cycle out_valid=0, out_ctrl=0, count=0, in_ready=1. out_data=0 when FLUSH_DATA=1; with FLUSH_DATA=0, out_data equals the pre-flush M.data. The concurrent input never appears on the output.
5. SKID_EN=0, M full, out_ready toggled 0/1 each cycle -> in_ready tracks out_ready combinationally, no payload is lost or duplicated over 20 random pushes, and the scoreboard order matches.
6. RST and flush asserted together at count=2 -> reset values as in scenario 1, including out_data=0 when FLUSH_DATA=0.
